// File: rtl/lrelu_cfg_writer.sv
// lrelu_cfg_writer: routes LReLU config beats into D / BRAM_A / BRAM_B through one registered write stage.
// Optional framing check (s_last vs counter full) enabled by LRELU_CFG_LAST_CHECK_EN.
`ifndef KH_MAX
`define KH_MAX 3
`endif
`ifndef KW_MAX
`define KW_MAX 3
`endif
`ifndef BITS_KH
`define BITS_KH 2
`endif
module lrelu_cfg_writer #(
    parameter int KH_MAX      = `KH_MAX,
    parameter int KW_MAX      = `KW_MAX,
    parameter int WORD_WIDTH  = 16,
    parameter int BITS_KH     = `BITS_KH,
    parameter int BITS_CLR_I  = $clog2(KW_MAX/2+1),
    parameter int BITS_W_ADDR = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WORD_WIDTH-1:0]  s_data,
    input  logic                   s_last,
    output logic                   cnt_en,
    input  logic [1:0]             w_sel,
    input  logic [BITS_CLR_I-1:0]  clr_i,
    input  logic [BITS_KH-1:0]     mtb,
    input  logic [BITS_W_ADDR-1:0] w_addr,
    input  logic                   full,
    output logic [WORD_WIDTH-1:0]  wr_data,
    output logic                   d_we,
    output logic                   a_we,
    output logic [BITS_W_ADDR-1:0] a_addr,
    output logic                   b_we,
    output logic [BITS_CLR_I-1:0]  b_clr_i,
    output logic [BITS_KH-1:0]     b_mtb,
    output logic [BITS_W_ADDR-1:0] b_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t state;
    wire [63:0] unused_params = {KH_MAX, KW_MAX};
    assign s_ready = state == LOAD && w_sel != 2'd0;
    assign cnt_en  = s_valid && s_ready;
    assign busy    = state == LOAD;
    assign done    = state == DONE;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            wr_data <= '0;
            d_we    <= 1'b0;
            a_we    <= 1'b0;
            b_we    <= 1'b0;
            a_addr  <= '0;
            b_clr_i <= '0;
            b_mtb   <= '0;
            b_addr  <= '0;
        end else begin
            d_we <= cnt_en && w_sel == 2'd1;
            a_we <= cnt_en && w_sel == 2'd2;
            b_we <= cnt_en && w_sel == 2'd3;
            if (cnt_en) wr_data <= s_data;
            if (cnt_en && w_sel == 2'd2) a_addr <= w_addr;
            if (cnt_en && w_sel == 2'd3) begin
                b_clr_i <= clr_i;
                b_mtb   <= mtb;
                b_addr  <= w_addr;
            end
            case (state)
                IDLE:    if (start) state <= LOAD;
                LOAD:    if (cnt_en && full) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef LRELU_CFG_LAST_CHECK_EN
    // Early last and missing last both flag; the load itself is never cut short.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err <= 1'b0;
        else if (state == IDLE && start) err <= 1'b0;
        else if (cnt_en && s_last != full) err <= 1'b1;
    end
`else
    wire unused_last = s_last;
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_lrelu_cfg_writer.sv
// tb_lrelu_cfg_writer: randomized self-checking bench with a table-driven counter stub and write scoreboard.
module tb_lrelu_cfg_writer;
`ifdef LRELU_CFG_LAST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int NB = 13;
    logic clk = 0, rstn = 0, start = 0, s_valid = 0, s_last = 0;
    logic [15:0] s_data = 0;
    logic s_ready, cnt_en, full, d_we, a_we, b_we, busy, done, err;
    logic [1:0] w_sel;
    logic [0:0] clr_i, b_clr_i;
    logic [1:0] mtb, b_mtb;
    logic [3:0] w_addr, a_addr, b_addr;
    logic [15:0] wr_data;
    logic ovr = 0, o_full = 0;
    logic [1:0] o_sel = 0, o_mtb = 0;
    logic [0:0] o_clr = 0;
    logic [3:0] o_addr = 0;
    logic [1:0] t_sel [NB];
    logic [0:0] t_clr [NB];
    logic [1:0] t_mtb [NB];
    logic [3:0] t_addr [NB];
    int idx;
    int n_chk = 0, n_fail = 0;
    int n_cnt = 0, n_done = 0, n_multi = 0;
    logic [24:0] got [$];
    logic [24:0] exp_q [$];

    lrelu_cfg_writer #(.KH_MAX(3), .KW_MAX(3), .WORD_WIDTH(16), .BITS_KH(2), .BITS_CLR_I(1), .BITS_W_ADDR(4)) dut (
        .clk(clk), .rstn(rstn), .start(start), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .cnt_en(cnt_en), .w_sel(w_sel), .clr_i(clr_i), .mtb(mtb), .w_addr(w_addr),
        .full(full), .wr_data(wr_data), .d_we(d_we), .a_we(a_we), .a_addr(a_addr), .b_we(b_we),
        .b_clr_i(b_clr_i), .b_mtb(b_mtb), .b_addr(b_addr), .busy(busy), .done(done), .err(err));

    always #5 clk = ~clk;

    // Counter stub: walks a fixed beat table (1 D, 4 BRAM_A, 2x2x2 BRAM_B), wrapping after full.
    assign w_sel  = ovr ? o_sel  : t_sel[idx];
    assign clr_i  = ovr ? o_clr  : t_clr[idx];
    assign mtb    = ovr ? o_mtb  : t_mtb[idx];
    assign w_addr = ovr ? o_addr : t_addr[idx];
    assign full   = ovr ? o_full : (idx == NB-1);
    always @(posedge clk or negedge rstn)
        if (!rstn) idx <= 0;
        else if (cnt_en && !ovr) idx <= (idx == NB-1) ? 0 : idx + 1;

    function automatic logic [24:0] wkey(input logic [1:0] sel, input logic [0:0] c, input logic [1:0] m,
                                         input logic [3:0] a, input logic [15:0] d);
        return {sel, sel == 2'd3 ? c : 1'b0, sel == 2'd3 ? m : 2'd0, sel >= 2'd2 ? a : 4'd0, d};
    endfunction

    always @(negedge clk) begin
        if (cnt_en) n_cnt++;
        if (done) n_done++;
        if ($countones({d_we, a_we, b_we}) > 1) n_multi++;
        if (d_we | a_we | b_we)
            got.push_back(wkey(d_we ? 2'd1 : a_we ? 2'd2 : 2'd3, b_clr_i, b_mtb, a_we ? a_addr : b_addr, wr_data));
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start;
        start = 1; idle(1); start = 0;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic l, output bit ok);
        ok = 0; s_valid = 1; s_data = d; s_last = l;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin @(posedge clk); #1; end
        s_valid = 0; s_last = 0;
    endtask

    task automatic test_reset;
        s_valid = 1; #1;
        n_chk++;
        if ({s_ready, cnt_en, d_we, a_we, b_we, busy, done, err} !== 8'h0) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 00000000", {s_ready, cnt_en, d_we, a_we, b_we, busy, done, err});
        end
        n_chk++;
        if ({wr_data, a_addr, b_clr_i, b_mtb, b_addr} !== 27'h0) begin
            n_fail++; $display("FAIL reset_data got %h want 0", {wr_data, a_addr, b_clr_i, b_mtb, b_addr});
        end
        s_valid = 0;
        @(negedge clk); rstn = 1; idle(2);
    endtask

    task automatic test_routing;
        bit ok;
        ovr = 1; o_sel = 0; o_full = 0;
        pulse_start;
        s_valid = 1; #1;
        n_chk++;
        if ({s_ready, cnt_en} !== 2'b00) begin
            n_fail++; $display("FAIL wsel0_ready got %b want 00", {s_ready, cnt_en});
        end
        idle(1); s_valid = 0;
        n_chk++;
        if ({d_we, a_we, b_we, busy} !== 4'b0001) begin
            n_fail++; $display("FAIL wsel0_nowrite got %b want 0001", {d_we, a_we, b_we, busy});
        end
        o_sel = 2; o_addr = 5;
        send_beat(16'hABCD, 0, ok);
        n_chk++;
        if (!ok || {d_we, a_we, b_we} !== 3'b010 || a_addr !== 4'd5 || wr_data !== 16'hABCD) begin
            n_fail++; $display("FAIL route_a got ok=%0d we=%b addr=%0d data=%h want we=010 addr=5 data=abcd",
                               ok, {d_we, a_we, b_we}, a_addr, wr_data);
        end
        o_sel = 3; o_clr = 1; o_mtb = 2; o_addr = 3;
        send_beat(16'h1234, 0, ok);
        n_chk++;
        if (!ok || {d_we, a_we, b_we} !== 3'b001 || b_clr_i !== 1'b1 || b_mtb !== 2'd2 || b_addr !== 4'd3
            || wr_data !== 16'h1234 || a_addr !== 4'd5) begin
            n_fail++; $display("FAIL route_b got ok=%0d we=%b clr=%0d mtb=%0d addr=%0d data=%h a_addr=%0d",
                               ok, {d_we, a_we, b_we}, b_clr_i, b_mtb, b_addr, wr_data, a_addr);
        end
        o_sel = 1; o_full = 1;
        send_beat(16'h5555, 1, ok);
        n_chk++;
        if (!ok || {d_we, a_we, b_we} !== 3'b100 || wr_data !== 16'h5555 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL route_d_final got ok=%0d we=%b data=%h done=%b busy=%b want we=100 data=5555 done=1 busy=0",
                               ok, {d_we, a_we, b_we}, wr_data, done, busy);
        end
        idle(1);
        n_chk++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL route_err got %b want 0", err);
        end
        ovr = 0; o_full = 0; o_sel = 0;
    endtask

    // One full load against the stub; optional mid-load stall with a stray start, optional bad framing.
    task automatic test_load(input string tag, input int stall_k, input int first_last, input bit final_last);
        bit ok, seen;
        int nw, i0, nd, na, nb;
        logic [15:0] d;
        bit exp_err = CHK && ((first_last >= 0 && first_last != NB-1) || !final_last);
        got.delete(); exp_q.delete(); n_cnt = 0; n_done = 0; n_multi = 0;
        pulse_start;
        n_chk++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL %s_start got busy=%b err=%b want busy=1 err=0", tag, busy, err);
        end
        for (int k = 0; k < NB; k++) begin
            if (k == stall_k) begin
                idle(1); nw = got.size(); i0 = idx;
                idle(4); pulse_start; idle(5);
                n_chk++;
                if (got.size() != nw || idx != i0 || busy !== 1'b1 || n_done != 0) begin
                    n_fail++; $display("FAIL %s_stall got writes=%0d idx=%0d busy=%b done=%0d want writes=%0d idx=%0d busy=1 done=0",
                                       tag, got.size(), idx, busy, n_done, nw, i0);
                end
            end
            idle($urandom_range(0, 2));
            d = 16'($urandom);
            send_beat(d, (k == first_last) || (final_last && k == NB-1), ok);
            n_chk++;
            if (!ok) begin
                n_fail++; $display("FAIL %s_accept beat %0d got not accepted want accepted", tag, k);
            end
            exp_q.push_back(wkey(t_sel[k], t_clr[k], t_mtb[k], t_addr[k], d));
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) begin seen = 1; break; end
            idle(1);
        end
        n_chk++;
        if (!seen) begin
            n_fail++; $display("FAIL %s_done got done=0 within 5 cycles want 1", tag);
        end
        idle(1);
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || n_done != 1 || n_cnt != NB || w_sel !== 2'd1 || n_multi != 0) begin
            n_fail++; $display("FAIL %s_end got busy=%b done=%b pulses=%0d cnt_en=%0d w_sel=%0d multi=%0d want 0 0 1 %0d 1 0",
                               tag, busy, done, n_done, n_cnt, w_sel, n_multi, NB);
        end
        nd = 0; na = 0; nb = 0;
        foreach (got[i]) begin
            if (got[i][24:23] == 2'd1) nd++;
            if (got[i][24:23] == 2'd2) na++;
            if (got[i][24:23] == 2'd3) nb++;
        end
        n_chk++;
        if (nd != 1 || na != 4 || nb != 8) begin
            n_fail++; $display("FAIL %s_counts got d=%0d a=%0d b=%0d want d=1 a=4 b=8", tag, nd, na, nb);
        end
        n_chk++;
        if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL %s_nwrites got %0d want %0d", tag, got.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_chk++;
                if (got[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL %s_write%0d got %h want %h", tag, i, got[i], exp_q[i]);
                end
            end
        end
        n_chk++;
        if (err !== exp_err) begin
            n_fail++; $display("FAIL %s_err got %b want %b", tag, err, exp_err);
        end
    endtask

    task automatic test_abort;
        bit ok;
        pulse_start;
        for (int k = 0; k < 3; k++) send_beat(16'($urandom), 0, ok);
        #2 rstn = 0; #1;
        n_chk++;
        if ({s_ready, cnt_en, d_we, a_we, b_we, busy, done, err} !== 8'h0 || {wr_data, a_addr, b_clr_i, b_mtb, b_addr} !== 27'h0) begin
            n_fail++; $display("FAIL abort_reset got ctrl=%b data=%h want 0 0",
                               {s_ready, cnt_en, d_we, a_we, b_we, busy, done, err}, {wr_data, a_addr, b_clr_i, b_mtb, b_addr});
        end
        @(negedge clk); rstn = 1; idle(1);
        test_load("after_abort", -1, -1, 1);
    endtask

    initial begin
        int n = 0;
        t_sel[n] = 1; t_clr[n] = 0; t_mtb[n] = 0; t_addr[n] = 0; n++;
        for (int a = 0; a < 4; a++) begin
            t_sel[n] = 2; t_clr[n] = 0; t_mtb[n] = 0; t_addr[n] = 4'(a); n++;
        end
        for (int c = 0; c < 2; c++)
            for (int m = 0; m < 2; m++)
                for (int a = 0; a < 2; a++) begin
                    t_sel[n] = 3; t_clr[n] = 1'(c); t_mtb[n] = 2'(m); t_addr[n] = 4'(a); n++;
                end
        #12;
        test_reset;
        test_routing;
        test_load("full1", -1, -1, 1);
        test_load("full2", -1, -1, 1);
        test_load("stall", 5, -1, 1);
        test_load("early_last", -1, 1, 1);
        test_load("after_err", -1, -1, 1);
        test_load("missing_last", -1, -1, 0);
        test_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
